// File: rtl/cam_search_ctrl_pkg.sv
// Shared types and default geometry for the CAM search controller.
package cam_pkg;

   localparam int CAM_DEPTH  = 16;
   localparam int CAM_WIDTH  = 32;
   localparam int CAM_ADDR_W = $clog2(CAM_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_SEARCH  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RESULT  = 3'd4
   } cam_state_t;

endpackage

// File: rtl/cam_search_ctrl_if.sv
// Request, result and cell-array signals of the CAM search controller.
interface cam_search_ctrl_if
   import cam_pkg::*;
#(
   parameter int DEPTH  = CAM_DEPTH,
   parameter int WIDTH  = CAM_WIDTH,
   parameter int ADDR_W = $clog2(DEPTH)
);
   logic              wr_valid_i;
   logic              wr_ready_o;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [WIDTH-1:0]  wr_data_i;
   logic              wr_inval_i;
   logic              srch_valid_i;
   logic              srch_ready_o;
   logic [WIDTH-1:0]  srch_key_i;
   logic              rslt_valid_o;
   logic              rslt_ready_i;
   logic              rslt_hit_o;
   logic [ADDR_W-1:0] rslt_idx_o;
   logic [DEPTH-1:0]  cell_wen_o;
   logic [WIDTH-1:0]  cell_wdata_o;
   logic              cell_search_o;
   logic [WIDTH-1:0]  cell_key_o;
   logic [DEPTH-1:0]  cell_match_i;

   modport master (
      output wr_valid_i, wr_addr_i, wr_data_i, wr_inval_i,
      output srch_valid_i, srch_key_i, rslt_ready_i, cell_match_i,
      input  wr_ready_o, srch_ready_o, rslt_valid_o, rslt_hit_o, rslt_idx_o,
      input  cell_wen_o, cell_wdata_o, cell_search_o, cell_key_o
   );

   modport slave (
      input  wr_valid_i, wr_addr_i, wr_data_i, wr_inval_i,
      input  srch_valid_i, srch_key_i, rslt_ready_i, cell_match_i,
      output wr_ready_o, srch_ready_o, rslt_valid_o, rslt_hit_o, rslt_idx_o,
      output cell_wen_o, cell_wdata_o, cell_search_o, cell_key_o
   );

endinterface

// File: rtl/cam_search_ctrl_prio_enc.sv
// Lowest-index priority encoder over the masked match vector; idx is 0 on miss.
module cam_prio_enc #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]  i_vec,
   output logic              o_hit,
   output logic [ADDR_W-1:0] o_idx
);

   always_comb begin
      o_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = ADDR_W'(i);
      end
   end

   assign o_hit = |i_vec;

endmodule

// File: rtl/cam_search_ctrl.sv
// CAM search controller: serialises writes/invalidates and searches to a cell array,
// keeps per-entry valid bits and reports the lowest valid matching entry.
//
// state   | meaning
// IDLE    | ready for a write (priority) or a search
// WRITE   | one-cycle cell write strobe, valid bit updated at exit
// SEARCH  | one-cycle search strobe with the registered key
// CAPTURE | cells present registered match; mask and encode
// RESULT  | hold hit/idx until the consumer takes it
module cam_search_ctrl
   import cam_pkg::*;
#(
   parameter int DEPTH  = CAM_DEPTH,
   parameter int WIDTH  = CAM_WIDTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic              clk,
   input logic              rst,
   cam_search_ctrl_if.slave bus
);

   cam_state_t        r_state;
   cam_state_t        w_next;
   logic [ADDR_W-1:0] r_addr;
   logic              r_addr_ok;
   logic              r_inval;
   logic [WIDTH-1:0]  r_data;
   logic [WIDTH-1:0]  r_key;
   logic [DEPTH-1:0]  r_valid;
   logic              r_hit;
   logic [ADDR_W-1:0] r_idx;

   logic              w_wr_acc;
   logic              w_srch_acc;
   logic              w_addr_ok;
   logic [DEPTH-1:0]  w_masked;
   logic              w_hit;
   logic [ADDR_W-1:0] w_idx;

   assign w_wr_acc   = (r_state == ST_IDLE) && bus.wr_valid_i;
   assign w_srch_acc = (r_state == ST_IDLE) && !bus.wr_valid_i && bus.srch_valid_i;
   // Out-of-range addresses are accepted but must touch neither cells nor valid bits.
   assign w_addr_ok  = ({1'b0, bus.wr_addr_i} < (ADDR_W + 1)'(DEPTH));
   assign w_masked   = bus.cell_match_i & r_valid;

   cam_prio_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prio_enc (
      .i_vec (w_masked),
      .o_hit (w_hit),
      .o_idx (w_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_acc)        w_next = ST_WRITE;
            else if (w_srch_acc) w_next = ST_SEARCH;
         end
         ST_WRITE:   w_next = ST_IDLE;
         ST_SEARCH:  w_next = ST_CAPTURE;
         ST_CAPTURE: w_next = ST_RESULT;
         ST_RESULT:  if (bus.rslt_ready_i) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.wr_ready_o    = 1'b0;
      bus.srch_ready_o  = 1'b0;
      bus.rslt_valid_o  = 1'b0;
      bus.cell_search_o = 1'b0;
      bus.cell_wen_o    = '0;
      case (r_state)
         ST_IDLE: begin
            bus.wr_ready_o   = 1'b1;
            bus.srch_ready_o = !bus.wr_valid_i;
         end
         ST_WRITE:  if (r_addr_ok && !r_inval) bus.cell_wen_o[r_addr] = 1'b1;
         ST_SEARCH: bus.cell_search_o = 1'b1;
         ST_RESULT: bus.rslt_valid_o  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_addr_ok <= 1'b0;
         r_inval   <= 1'b0;
         r_data    <= '0;
         r_key     <= '0;
         r_valid   <= '0;
         r_hit     <= 1'b0;
         r_idx     <= '0;
      end else begin
         if (w_wr_acc) begin
            r_addr    <= bus.wr_addr_i;
            r_addr_ok <= w_addr_ok;
            r_inval   <= bus.wr_inval_i;
            r_data    <= bus.wr_data_i;
         end
         if (w_srch_acc) r_key <= bus.srch_key_i;
         if (r_state == ST_WRITE && r_addr_ok) r_valid[r_addr] <= !r_inval;
         if (r_state == ST_CAPTURE) begin
            r_hit <= w_hit;
            r_idx <= w_idx;
         end
      end
   end

   assign bus.rslt_hit_o   = r_hit;
   assign bus.rslt_idx_o   = r_idx;
   assign bus.cell_wdata_o = r_data;
   assign bus.cell_key_o   = r_key;

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Scoreboard bench for cam_search_ctrl with a behavioural cell array and CAM reference model.
module tb_cam_search_ctrl;
   import cam_pkg::*;

   localparam int DEPTH = CAM_DEPTH;
   localparam int WIDTH = CAM_WIDTH;
   localparam int AW    = CAM_ADDR_W;

   typedef struct {
      logic          hit;
      logic [AW-1:0] idx;
      int            acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cam_search_ctrl_if bus ();

   cam_search_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t             sb[$];
   int               total = 0;
   int               bad   = 0;
   int               cyc   = 0;
   logic [WIDTH-1:0] cell_mem [DEPTH];
   logic [WIDTH-1:0] ref_data [DEPTH];
   logic             ref_valid[DEPTH];
   logic             rdy_rand  = 1'b0;
   logic             rdy_force = 1'b1;
   logic             prev_valid = 1'b0;
   logic [WIDTH-1:0] pool[4] = '{32'h0BAD_F00D, 32'h1111_2222, 32'hCAFE_0001, 32'h7777_7777};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic exp_t lookup(input logic [WIDTH-1:0] k);
      exp_t e;
      e.hit = 1'b0;
      e.idx = '0;
      e.acc = 0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ref_valid[i] && ref_data[i] == k) begin
            e.hit = 1'b1;
            e.idx = AW'(i);
         end
      end
      return e;
   endfunction

   // Cell array: writes on strobe, match registered one cycle after the search strobe.
   always @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.cell_wen_o[i]) cell_mem[i] <= bus.cell_wdata_o;
         bus.cell_match_i[i] <= bus.cell_search_o && (cell_mem[i] == bus.cell_key_o);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      bus.rslt_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else if (bus.rslt_valid_o) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rslt: got valid=1 want valid=0");
         end else begin
            if (!prev_valid) chk("lat_edges", 64'(cyc - sb[0].acc), 64'd2);
            chk("rslt_hit", 64'(bus.rslt_hit_o), 64'(sb[0].hit));
            chk("rslt_idx", 64'(bus.rslt_idx_o), 64'(sb[0].idx));
            chk("readys_in_result", 64'({bus.wr_ready_o, bus.srch_ready_o}), 64'd0);
            if (bus.rslt_ready_i) void'(sb.pop_front());
         end
         prev_valid = !bus.rslt_ready_i;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic inv);
      bit ok = 1'b0;
      @(negedge clk);
      bus.wr_valid_i = 1'b1;
      bus.wr_addr_i  = a;
      bus.wr_data_i  = d;
      bus.wr_inval_i = inv;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (bus.wr_ready_o) begin
            ok = 1'b1;
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      if (ok) begin
         ref_valid[a] = !inv;
         if (!inv) ref_data[a] = d;
      end else begin
         chk("wr_accept_timeout", 64'd0, 64'd1);
      end
      @(negedge clk);
      bus.wr_valid_i = 1'b0;
   endtask

   task automatic do_search(input logic [WIDTH-1:0] k);
      bit   ok = 1'b0;
      exp_t e;
      @(negedge clk);
      bus.srch_valid_i = 1'b1;
      bus.srch_key_i   = k;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (bus.srch_ready_o) begin
            ok = 1'b1;
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      e = lookup(k);
      @(negedge clk);
      bus.srch_valid_i = 1'b0;
      if (ok) begin
         e.acc = cyc;
         sb.push_back(e);
      end else begin
         chk("srch_accept_timeout", 64'd0, 64'd1);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
      chk("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      bus.wr_valid_i   = 1'b0;
      bus.wr_addr_i    = '0;
      bus.wr_data_i    = '0;
      bus.wr_inval_i   = 1'b0;
      bus.srch_valid_i = 1'b0;
      bus.srch_key_i   = '0;
      bus.rslt_ready_i = 1'b1;
      bus.cell_match_i = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cell_mem[i]  = '0;
         ref_data[i]  = '0;
         ref_valid[i] = 1'b0;
      end

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("idle_wr_ready",   64'(bus.wr_ready_o),    64'd1);
      chk("idle_srch_ready", 64'(bus.srch_ready_o),  64'd1);
      chk("idle_rslt_valid", 64'(bus.rslt_valid_o),  64'd0);
      chk("idle_rslt_hit",   64'(bus.rslt_hit_o),    64'd0);
      chk("idle_rslt_idx",   64'(bus.rslt_idx_o),    64'd0);
      chk("idle_cell_wen",   64'(bus.cell_wen_o),    64'd0);
      chk("idle_cell_srch",  64'(bus.cell_search_o), 64'd0);
      chk("idle_cell_wdata", 64'(bus.cell_wdata_o),  64'd0);
      chk("idle_cell_key",   64'(bus.cell_key_o),    64'd0);

      // Cells hold zero but no entry is valid yet: must miss.
      do_search(32'h0000_0000);
      drain();

      do_write(4'd3, 32'hDEAD_BEEF, 1'b0);
      do_search(32'hDEAD_BEEF);
      drain();

      do_write(4'd9, 32'h1234_5678, 1'b0);
      do_write(4'd5, 32'h1234_5678, 1'b0);
      do_search(32'h1234_5678);
      do_write(4'd5, 32'h0, 1'b1);
      do_search(32'h1234_5678);
      drain();

      fork
         do_write(4'd2, 32'hA5A5_A5A5, 1'b0);
         do_search(32'hA5A5_A5A5);
      join
      drain();

      rdy_force = 1'b0;
      do_search(32'hDEAD_BEEF);
      for (int n = 0; n < 20 && !bus.rslt_valid_o; n++) @(negedge clk);
      repeat (4) @(negedge clk);
      rdy_force = 1'b1;
      drain();

      // Reset while the search strobe is out: the result must be dropped.
      do_search(32'h1234_5678);
      rst = 1'b1;
      sb.delete();
      for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_wr_ready",   64'(bus.wr_ready_o),   64'd1);
      chk("post_rst_rslt_valid", 64'(bus.rslt_valid_o), 64'd0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (bus.rslt_valid_o) seen++;
      end
      chk("post_rst_no_result", 64'(seen), 64'd0);

      rdy_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(AW'($urandom_range(0, DEPTH - 1)), pool[$urandom_range(0, 3)],
                     $urandom_range(0, 4) == 0);
         else
            do_search(pool[$urandom_range(0, 3)]);
      end
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
